// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side and execute-side handshake bundle of the decode stage
interface decode_stage_if #(parameter int PC_W = 32);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_ir;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [31:0]     out_ir;
    logic [6:0]      opcode;
    logic            reg_write;
    logic            mem_write;
    logic            mem_read;
    logic            is_branch;
    logic [3:0]      alu_fun;
    logic            alu_src_a;
    logic [1:0]      alu_src_b;
    logic [1:0]      rf_wr_sel;
    logic            illegal;
    modport slave (
        input  in_valid, in_ir, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_ir, opcode, reg_write, mem_write,
               mem_read, is_branch, alu_fun, alu_src_a, alu_src_b, rf_wr_sel, illegal
    );
    modport master (
        output in_valid, in_ir, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_ir, opcode, reg_write, mem_write,
               mem_read, is_branch, alu_fun, alu_src_a, alu_src_b, rf_wr_sel, illegal
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: queued RV32I decoder with a registered, flow-controlled control bundle
module decode_stage #(
    parameter int QDEPTH     = 4,
    parameter int PC_W       = 32,
    parameter int ENABLE_CSR = 1
) (
    input logic           clk,
    input logic           rst_n,
    input logic           flush,
    decode_stage_if.slave bus
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);
    logic [31:0]     r_q_ir [QDEPTH];
    logic [PC_W-1:0] r_q_pc [QDEPTH];
    logic [AW-1:0]   r_wptr, r_rptr;
    logic [CW-1:0]   r_count;
    logic            r_valid, r_reg_write, r_mem_write, r_mem_read, r_is_branch, r_alu_src_a, r_illegal;
    logic [PC_W-1:0] r_pc;
    logic [31:0]     r_ir;
    logic [3:0]      r_alu_fun;
    logic [1:0]      r_alu_src_b, r_rf_wr_sel;
    logic            w_in_ready, w_push, w_load;
    logic [31:0]     w_ir;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic            w_alt;
    logic            w_reg_write, w_mem_write, w_mem_read, w_is_branch, w_alu_src_a, w_illegal;
    logic [3:0]      w_alu_fun;
    logic [1:0]      w_alu_src_b, w_rf_wr_sel;
    assign w_in_ready = r_count < CW'(QDEPTH);
    assign w_push     = bus.in_valid && w_in_ready;
    assign w_load     = (r_count != '0) && (!r_valid || bus.out_ready);
    assign w_ir       = r_q_ir[r_rptr];
    assign w_f3       = w_ir[14:12];
    assign w_f7       = w_ir[31:25];
    assign w_alt      = w_f7 == 7'b0100000;
    // queue storage; entries are only meaningful while counted, so no reset is needed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_ir[r_wptr] <= bus.in_ir;
            r_q_pc[r_wptr] <= bus.in_pc;
        end
    end
    // queue pointers and occupancy; flush discards everything including a same-cycle push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= w_push ? r_wptr + 1'b1 : r_wptr;
            r_rptr  <= w_load ? r_rptr + 1'b1 : r_rptr;
            r_count <= r_count + CW'(w_push) - CW'(w_load);
        end
    end
    // decode of the queue head; illegal encodings suppress every architectural side effect
    always_comb begin
        w_reg_write = 1'b0;
        w_mem_write = 1'b0;
        w_mem_read  = 1'b0;
        w_is_branch = 1'b0;
        w_alu_fun   = 4'b0000;
        w_alu_src_a = 1'b0;
        w_alu_src_b = 2'b00;
        w_rf_wr_sel = 2'b00;
        w_illegal   = 1'b0;
        case (w_ir[6:0])
            7'b0110111: begin w_alu_fun = 4'b1001; w_reg_write = 1'b1; end
            7'b0010111: begin w_alu_src_a = 1'b1; w_reg_write = 1'b1; end
            7'b1101111, 7'b1100111: begin w_alu_src_a = 1'b1; w_alu_src_b = 2'b10; w_reg_write = 1'b1; end
            7'b0000011: begin w_mem_read = 1'b1; w_reg_write = 1'b1; w_rf_wr_sel = 2'b01; end
            7'b0100011: w_mem_write = 1'b1;
            7'b1100011: begin w_is_branch = 1'b1; w_alu_src_b = 2'b01; end
            7'b0010011: begin
                w_reg_write = 1'b1;
                w_alu_fun   = (w_f3 == 3'b101 && w_ir[30]) ? 4'b1101 : {1'b0, w_f3};
                w_illegal   = (w_f3 == 3'b001 && w_f7 != 7'b0) || (w_f3 == 3'b101 && w_f7 != 7'b0 && !w_alt);
            end
            7'b0110011: begin
                w_reg_write = 1'b1;
                w_alu_src_b = 2'b01;
                w_alu_fun   = (w_f3 == 3'b000 && w_alt) ? 4'b1000 :
                              (w_f3 == 3'b101 && w_ir[30]) ? 4'b1101 : {1'b0, w_f3};
                w_illegal   = (w_f7 != 7'b0 && !w_alt) || (w_alt && w_f3 != 3'b000 && w_f3 != 3'b101);
            end
            7'b1110011: begin
                w_alu_src_b = 2'b01;
                if (w_f3 != 3'b000) begin
                    if (ENABLE_CSR != 0) begin
                        w_reg_write = 1'b1;
                        w_rf_wr_sel = 2'b10;
                    end else begin
                        w_illegal = 1'b1;
                    end
                end
            end
            default: w_illegal = 1'b1;
        endcase
        if (w_illegal) begin
            w_reg_write = 1'b0;
            w_mem_write = 1'b0;
            w_mem_read  = 1'b0;
            w_is_branch = 1'b0;
        end
    end
    // output register: refills from the queue head whenever the bundle is empty or being consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_ir        <= '0;
            r_reg_write <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_is_branch <= 1'b0;
            r_alu_fun   <= '0;
            r_alu_src_a <= 1'b0;
            r_alu_src_b <= '0;
            r_rf_wr_sel <= '0;
            r_illegal   <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid     <= 1'b1;
            r_pc        <= r_q_pc[r_rptr];
            r_ir        <= w_ir;
            r_reg_write <= w_reg_write;
            r_mem_write <= w_mem_write;
            r_mem_read  <= w_mem_read;
            r_is_branch <= w_is_branch;
            r_alu_fun   <= w_alu_fun;
            r_alu_src_a <= w_alu_src_a;
            r_alu_src_b <= w_alu_src_b;
            r_rf_wr_sel <= w_rf_wr_sel;
            r_illegal   <= w_illegal;
        end else if (r_valid && bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_valid;
    assign bus.out_pc    = r_pc;
    assign bus.out_ir    = r_ir;
    assign bus.opcode    = r_ir[6:0];
    assign bus.reg_write = r_reg_write;
    assign bus.mem_write = r_mem_write;
    assign bus.mem_read  = r_mem_read;
    assign bus.is_branch = r_is_branch;
    assign bus.alu_fun   = r_alu_fun;
    assign bus.alu_src_a = r_alu_src_a;
    assign bus.alu_src_b = r_alu_src_b;
    assign bus.rf_wr_sel = r_rf_wr_sel;
    assign bus.illegal   = r_illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed checks of queueing, handshake, flush, reset and decode
module tb_decode_stage;
    logic clk, rst_n, flush;
    int n_cmp = 0;
    int n_fail = 0;
    decode_stage_if #(.PC_W(32)) bus ();
    decode_stage_if #(.PC_W(32)) bus0 ();
    decode_stage #(.QDEPTH(4), .PC_W(32), .ENABLE_CSR(1)) dut (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus));
    decode_stage #(.QDEPTH(4), .PC_W(32), .ENABLE_CSR(0)) dut0 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus0));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic send(input logic [31:0] ir, input logic [31:0] pc);
        bus.in_ir = ir; bus.in_pc = pc; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
    endtask
    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        n_cmp++; if ({bus.reg_write, bus.mem_write, bus.mem_read, bus.is_branch, bus.illegal} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {bus.reg_write, bus.mem_write, bus.mem_read, bus.is_branch, bus.illegal}); end
        n_cmp++; if ({bus.out_pc, bus.out_ir} !== 64'h0) begin n_fail++; $display("FAIL reset_pc_ir: got %h want 0", {bus.out_pc, bus.out_ir}); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask
    task automatic test_addi();
        bus.out_ready = 1'b1;
        bus.in_ir = 32'h00500093; bus.in_pc = 32'h100; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_early_valid: got %b want 0", bus.out_valid); end
        @(posedge clk); #1;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %b want 1", bus.out_valid); end
        n_cmp++; if ({bus.reg_write, bus.alu_fun, bus.alu_src_b, bus.rf_wr_sel, bus.illegal} !== {1'b1, 4'b0000, 2'b00, 2'b00, 1'b0}) begin n_fail++; $display("FAIL addi_ctrl: got %b want 1000000000", {bus.reg_write, bus.alu_fun, bus.alu_src_b, bus.rf_wr_sel, bus.illegal}); end
        n_cmp++; if (bus.out_pc !== 32'h100 || bus.opcode !== 7'h13) begin n_fail++; $display("FAIL addi_pc_opcode: got %h/%h want 100/13", bus.out_pc, bus.opcode); end
        @(posedge clk); #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain: got %b want 0", bus.out_valid); end
    endtask
    task automatic test_backpressure();
        int accepted;
        accepted = 0;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 10 && accepted < 6; k++) begin
            bus.in_ir = 32'h00100093 + (accepted << 20);
            bus.in_pc = 32'h200 + 4 * accepted;
            if (!bus.in_ready) break;
            @(posedge clk); #1;
            accepted++;
        end
        bus.in_valid = 1'b0;
        n_cmp++; if (accepted !== 5) begin n_fail++; $display("FAIL bp_accepts: got %0d want 5", accepted); end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", bus.in_ready); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h200 || bus.out_ir !== 32'h00100093) begin n_fail++; $display("FAIL bp_hold: got %b/%h/%h want 1/200/00100093", bus.out_valid, bus.out_pc, bus.out_ir); end
        bus.out_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h200 + 4 * j) begin n_fail++; $display("FAIL bp_drain_%0d: got %b/%h want 1/%h", j, bus.out_valid, bus.out_pc, 32'h200 + 4 * j); end
            @(posedge clk); #1;
        end
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_empty: got %b/%b want 0/1", bus.out_valid, bus.in_ready); end
    endtask
    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        bus.in_ir = 32'h4020D093; bus.in_pc = 32'h300; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_ir = 32'h40208033; bus.in_pc = 32'h304;
        @(posedge clk); #1;
        n_cmp++; if (bus.alu_fun !== 4'b1101 || bus.illegal !== 1'b0) begin n_fail++; $display("FAIL srai_alu_fun: got %b/%b want 1101/0", bus.alu_fun, bus.illegal); end
        bus.in_ir = 32'h0000A083; bus.in_pc = 32'h308;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.alu_fun !== 4'b1000 || bus.alu_src_b !== 2'b01 || bus.out_pc !== 32'h304) begin n_fail++; $display("FAIL sub_ctrl: got %b/%b/%h want 1000/01/304", bus.alu_fun, bus.alu_src_b, bus.out_pc); end
        @(posedge clk); #1;
        n_cmp++; if ({bus.mem_read, bus.reg_write, bus.rf_wr_sel, bus.mem_write} !== 5'b11010) begin n_fail++; $display("FAIL lw_ctrl: got %b want 11010", {bus.mem_read, bus.reg_write, bus.rf_wr_sel, bus.mem_write}); end
        @(posedge clk); #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", bus.out_valid); end
    endtask
    task automatic test_decode_misc();
        bus.out_ready = 1'b1;
        send(32'h123450B7, 32'h400);
        n_cmp++; if ({bus.alu_fun, bus.alu_src_a, bus.alu_src_b, bus.reg_write} !== {4'b1001, 1'b0, 2'b00, 1'b1}) begin n_fail++; $display("FAIL lui_ctrl: got %b want 10010001", {bus.alu_fun, bus.alu_src_a, bus.alu_src_b, bus.reg_write}); end
        send(32'h0020A023, 32'h404);
        n_cmp++; if ({bus.mem_write, bus.reg_write, bus.mem_read} !== 3'b100) begin n_fail++; $display("FAIL sw_ctrl: got %b want 100", {bus.mem_write, bus.reg_write, bus.mem_read}); end
        send(32'h00208463, 32'h408);
        n_cmp++; if ({bus.is_branch, bus.alu_src_b, bus.reg_write} !== 4'b1010) begin n_fail++; $display("FAIL beq_ctrl: got %b want 1010", {bus.is_branch, bus.alu_src_b, bus.reg_write}); end
        send(32'h008000EF, 32'h40C);
        n_cmp++; if ({bus.alu_src_a, bus.alu_src_b, bus.reg_write, bus.alu_fun} !== 8'b1101_0000) begin n_fail++; $display("FAIL jal_ctrl: got %b want 11010000", {bus.alu_src_a, bus.alu_src_b, bus.reg_write, bus.alu_fun}); end
        @(posedge clk); #1;
    endtask
    task automatic test_flush();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.in_ir = 32'h00100113; bus.in_pc = 32'h500 + 4 * k;
            @(posedge clk); #1;
        end
        bus.in_ir = 32'h00900093; bus.in_pc = 32'h999;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b want 1", bus.in_ready); end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty_%0d: got %b want 0", k, bus.out_valid); end
        end
        send(32'h00300093, 32'h600);
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h600) begin n_fail++; $display("FAIL flush_resume: got %b/%h want 1/600", bus.out_valid, bus.out_pc); end
        @(posedge clk); #1;
    endtask
    task automatic test_illegal();
        bus.out_ready = 1'b1;
        send(32'h00000000, 32'h700);
        n_cmp++; if ({bus.illegal, bus.reg_write, bus.mem_write, bus.mem_read, bus.is_branch} !== 5'b10000) begin n_fail++; $display("FAIL ill_zero: got %b want 10000", {bus.illegal, bus.reg_write, bus.mem_write, bus.mem_read, bus.is_branch}); end
        send(32'hFE208033, 32'h704);
        n_cmp++; if ({bus.illegal, bus.reg_write, bus.mem_write, bus.mem_read, bus.is_branch} !== 5'b10000) begin n_fail++; $display("FAIL ill_f7: got %b want 10000", {bus.illegal, bus.reg_write, bus.mem_write, bus.mem_read, bus.is_branch}); end
        send(32'h4020F033, 32'h708);
        n_cmp++; if ({bus.illegal, bus.reg_write} !== 2'b10) begin n_fail++; $display("FAIL ill_alt_f3: got %b want 10", {bus.illegal, bus.reg_write}); end
        send(32'h40209093, 32'h70C);
        n_cmp++; if ({bus.illegal, bus.reg_write} !== 2'b10) begin n_fail++; $display("FAIL ill_slli_f7: got %b want 10", {bus.illegal, bus.reg_write}); end
        @(posedge clk); #1;
    endtask
    task automatic test_csr();
        bus.out_ready = 1'b1;
        bus0.out_ready = 1'b1;
        bus.in_ir = 32'h30529073; bus.in_pc = 32'h800; bus.in_valid = 1'b1;
        bus0.in_ir = 32'h30529073; bus0.in_pc = 32'h800; bus0.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus0.in_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if ({bus.out_valid, bus.illegal, bus.reg_write, bus.rf_wr_sel, bus.alu_src_b} !== 7'b1011001) begin n_fail++; $display("FAIL csr_on: got %b want 1011001", {bus.out_valid, bus.illegal, bus.reg_write, bus.rf_wr_sel, bus.alu_src_b}); end
        n_cmp++; if ({bus0.out_valid, bus0.illegal, bus0.reg_write, bus0.rf_wr_sel} !== 5'b11000) begin n_fail++; $display("FAIL csr_off: got %b want 11000", {bus0.out_valid, bus0.illegal, bus0.reg_write, bus0.rf_wr_sel}); end
        @(posedge clk); #1;
    endtask
    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_ir = 32'h00500093; bus.in_pc = 32'h900;
        repeat (5) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL ar_full: got %b/%b want 0/1", bus.in_ready, bus.out_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_async: got %b/%b want 1/0", bus.in_ready, bus.out_valid); end
        n_cmp++; if (bus.out_pc !== 32'h0 || bus.reg_write !== 1'b0) begin n_fail++; $display("FAIL ar_outputs: got %h/%b want 0/0", bus.out_pc, bus.reg_write); end
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        send(32'h0000A083, 32'hA00);
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'hA00 || bus.mem_read !== 1'b1) begin n_fail++; $display("FAIL ar_resume: got %b/%h/%b want 1/a00/1", bus.out_valid, bus.out_pc, bus.mem_read); end
        @(posedge clk); #1;
    endtask
    initial begin
        flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_ir = '0; bus.in_pc = '0; bus.out_ready = 1'b0;
        bus0.in_valid = 1'b0; bus0.in_ir = '0; bus0.in_pc = '0; bus0.out_ready = 1'b1;
        test_reset();
        test_addi();
        test_backpressure();
        test_back_to_back();
        test_decode_misc();
        test_flush();
        test_illegal();
        test_csr();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
